pipe_mdu: RTL and testbench
===========================

PIPE_MDU -- requirements
Module: pipe_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width; legal values 8..64.
REQ-002 SHALL have parameter MULT_CYCLES, default 5, busy cycles for mult-class ops; legal values 1..31.
REQ-003 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div-class ops; legal values 1..63.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 start  input  1  launches the op on mdu_op this cycle.
REQ-007 mdu_op  input  4  0 nope, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; 11-15 treated as nope.
REQ-008 req  input  1  exception/interrupt flush from the M stage.
REQ-009 d1  input  WIDTH  rs operand.
REQ-010 d2  input  WIDTH  rt operand.
REQ-011 busy  output  1  high while an op is in flight.
REQ-012 done  output  1  one-cycle pulse in the cycle after HI/LO commit.
REQ-013 hi  output  WIDTH  architectural HI.
REQ-014 lo  output  WIDTH  architectural LO.

Function
REQ-015 SHALL implement FSM IDLE, MUL, DIV; busy = (state != IDLE), registered.
REQ-016 Accept condition: start=1, req=0, state IDLE, mdu_op in 1-4 or 7-10; otherwise start is ignored with no state change.
REQ-017 On accept SHALL capture d1, d2, and op into internal registers and compute the result from captured values only.
REQ-018 Mult-class ops (1,2,7-10) SHALL enter MUL; div-class ops (3,4) SHALL enter DIV.
REQ-019 A down-counter SHALL be loaded with MULT_CYCLES-1 or DIV_CYCLES-1 on accept, decrement each cycle, and be sized $clog2(DIV_CYCLES+1).
REQ-020 busy SHALL be high for exactly MULT_CYCLES or DIV_CYCLES cycles, starting the cycle after accept.
REQ-021 HI/LO SHALL commit on the edge that returns the FSM to IDLE; hi/lo SHALL hold their old values while busy.
REQ-022 mult/multu: {hi,lo} = 2*WIDTH-bit product, signed or unsigned.
REQ-023 madd/maddu/msub/msubu: {hi,lo} = {hi,lo} +/- product, using HI/LO values at commit time, modulo 2^(2*WIDTH).
REQ-024 div/divu: lo = quotient truncated toward zero; hi = remainder with the sign of d1.
REQ-025 Divide by zero: lo = all ones; hi = d1.
REQ-026 Signed overflow (d1 = most-negative, d2 = -1): lo = d1; hi = 0.
REQ-027 mthi/mtlo with start=1, req=0, and IDLE: hi or lo = d1 on the next edge; busy stays 0; done does not pulse.
REQ-028 mthi/mtlo when busy SHALL be ignored.
REQ-029 req=1 blocks acceptance in that cycle only; an op already in flight SHALL run to completion and commit regardless of req.
REQ-030 start is ignored while busy, including on the final busy cycle; the next op can be accepted in the first IDLE cycle.
REQ-031 done SHALL be registered and high exactly one cycle after each MUL/DIV commit.

Reset
REQ-032 While reset=0, asynchronously: state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, captured operands=0.
REQ-033 Reset asserted mid-operation SHALL abort the op with no HI/LO commit; after release the block is IDLE and accepts start on the first clk edge.

Verification
REQ-034 Defaults; mult with d1=0xFFFFFFFE (-2), d2=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
REQ-035 divu 100/7, then div -7/2 -> first op busy 10 cycles, hi=2, lo=14; second op lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-036 div with d2=0, d1=0x1234 -> lo=0xFFFFFFFF, hi=0x1234; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 mthi 5, mtlo 6, maddu 0x10*0x10 -> hi=5, lo=0x106; then msubu 0x10*0x10 -> hi=5, lo=6.
REQ-038 start mult with req=1 -> busy stays 0 and hi/lo unchanged; req pulsed during an in-flight mult -> commits normally; mtlo while busy -> ignored.
REQ-039 Assert reset at busy cycle 3 of a div -> busy=0, hi=lo=0 immediately; WIDTH=16, MULT_CYCLES=1 build: multu 0xFFFF*0xFFFF -> hi=0xFFFE, lo=0x0001 after one busy cycle.

Source files
------------

// File: rtl/pipe_mdu_if.sv
// Bus bundle for pipe_mdu: issue side (start/op/req/operands) and the
// architectural HI/LO plus status coming back.
//   master: drives start, mdu_op, req, d1, d2; observes busy, done, hi, lo
//   slave : the MDU itself
interface pipe_mdu_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       mdu_op;
  logic             req;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, mdu_op, req, d1, d2,
                  input  busy, done, hi, lo);
  modport slave  (input  start, mdu_op, req, d1, d2,
                  output busy, done, hi, lo);
endinterface

// File: rtl/pipe_mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - pipe_mdu_if.slave: start/mdu_op/req/d1/d2 in, busy/done/hi/lo out
// An accepted op latches its operands, holds busy for a fixed number of
// cycles, then commits HI/LO on the edge back to IDLE; done follows one
// cycle later. mthi/mtlo write directly from IDLE without going busy.
module pipe_mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  pipe_mdu_if.slave  bus
);
  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam int W2 = 2 * WIDTH;

  localparam logic [3:0] OP_MULT  = 4'd1, OP_MULTU = 4'd2,
                         OP_DIV   = 4'd3, OP_DIVU  = 4'd4,
                         OP_MTHI  = 4'd5, OP_MTLO  = 4'd6,
                         OP_MADD  = 4'd7, OP_MADDU = 4'd8,
                         OP_MSUB  = 4'd9, OP_MSUBU = 4'd10;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // ---- issue decode ----
  logic is_mul, is_div, is_mt, can_issue;
  always_comb begin
    is_mul    = (bus.mdu_op == OP_MULT)  || (bus.mdu_op == OP_MULTU) ||
                (bus.mdu_op == OP_MADD)  || (bus.mdu_op == OP_MADDU) ||
                (bus.mdu_op == OP_MSUB)  || (bus.mdu_op == OP_MSUBU);
    is_div    = (bus.mdu_op == OP_DIV)   || (bus.mdu_op == OP_DIVU);
    is_mt     = (bus.mdu_op == OP_MTHI)  || (bus.mdu_op == OP_MTLO);
    can_issue = bus.start && !bus.req && (state_q == IDLE);
  end

  // ---- datapath on captured operands ----
  // Multiply: extend both operands to 2*WIDTH (sign or zero); the low
  // 2*WIDTH bits of that product are the exact signed/unsigned result.
  logic             mul_sgn;
  logic [W2-1:0]    ea, eb, prod;
  always_comb begin
    mul_sgn = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    ea   = mul_sgn ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    eb   = mul_sgn ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod = ea * eb;
  end

  // Divide: unsigned divide on magnitudes, then restore signs. The
  // most-negative / -1 case falls out naturally: the magnitude quotient
  // 2^(WIDTH-1) re-reads as the most-negative value, remainder 0.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b, q_mag, r_mag, quo, rem;
  always_comb begin
    a_neg = (op_q == OP_DIV) && a_q[WIDTH-1];
    b_neg = (op_q == OP_DIV) && b_q[WIDTH-1];
    mag_a = a_neg ? -a_q : a_q;
    mag_b = b_neg ? -b_q : b_q;
    q_mag = (mag_b == '0) ? '0 : mag_a / mag_b;
    r_mag = (mag_b == '0) ? '0 : mag_a % mag_b;
    quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem   = a_neg ? -r_mag : r_mag;
  end

  logic [W2-1:0] res;
  always_comb begin
    unique case (op_q)
      OP_MULT, OP_MULTU: res = prod;
      OP_MADD, OP_MADDU: res = {hi_q, lo_q} + prod;
      OP_MSUB, OP_MSUBU: res = {hi_q, lo_q} - prod;
      OP_DIV,  OP_DIVU:  res = (b_q == '0) ? {a_q, {WIDTH{1'b1}}} : {rem, quo};
      default:           res = {hi_q, lo_q};
    endcase
  end

  // ---- control ----
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (can_issue && (is_mul || is_div)) begin
          state_d = is_div ? DIV : MUL;
          cnt_d   = is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
          a_d     = bus.d1;
          b_d     = bus.d2;
          op_d    = bus.mdu_op;
        end else if (can_issue && is_mt) begin
          if (bus.mdu_op == OP_MTHI) hi_d = bus.d1;
          else                       lo_d = bus.d1;
        end
      end
      MUL, DIV: begin
        // In-flight ops ignore start and req; they always finish.
        if (cnt_q == '0) begin
          state_d      = IDLE;
          {hi_d, lo_d} = res;
          done_d       = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_pipe_mdu.sv
// Scoreboard bench for pipe_mdu: stimulus pushes the expected {hi,lo}
// into a queue; monitors pop and compare on every done pulse. A second
// instance (WIDTH=16, MULT_CYCLES=1) covers the narrow single-cycle build.
module tb_pipe_mdu;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipe_mdu_if #(.WIDTH(32)) if32 ();
  pipe_mdu_if #(.WIDTH(16)) if16 ();

  pipe_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
    .clk(clk), .reset(reset), .bus(if32));
  pipe_mdu #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(10)) u_dut16 (
    .clk(clk), .reset(reset), .bus(if16));

  int errors = 0;
  int checks = 0;
  logic [63:0] q32[$];
  logic [31:0] q16[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---- monitors ----
  always @(negedge clk) begin
    if (reset && if32.done === 1'b1) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL done32_unexpected: got done=1 expected no pending op");
      end else begin
        logic [63:0] e;
        e = q32.pop_front();
        chk("hilo32", {if32.hi, if32.lo}, e);
      end
    end
  end

  always @(negedge clk) begin
    if (reset && if16.done === 1'b1) begin
      if (q16.size() == 0) begin
        checks++; errors++;
        $display("FAIL done16_unexpected: got done=1 expected no pending op");
      end else begin
        logic [31:0] e;
        e = q16.pop_front();
        chk("hilo16", {32'h0, if16.hi, if16.lo}, {32'h0, e});
      end
    end
  end

  // poke: 0 none, 1 mtlo 0xDEAD on the final busy cycle, 2 req on busy cycle 2
  task automatic run32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int cyc, input int poke);
    int n;
    q32.push_back(exp);
    if32.mdu_op = op; if32.d1 = a; if32.d2 = b; if32.start = 1'b1;
    @(posedge clk); #1;
    if32.start = 1'b0;
    n = 0;
    while (if32.busy === 1'b1 && n < 200) begin
      n++;
      if (poke == 1 && n == cyc) begin
        if32.start = 1'b1; if32.mdu_op = 4'd6; if32.d1 = 32'hDEAD;
      end
      if (poke == 2 && n == 2) if32.req = 1'b1;
      @(posedge clk); #1;
      if32.start = 1'b0; if32.req = 1'b0;
    end
    chk("busy_cycles", 64'(n), 64'(cyc));
  endtask

  task automatic mt32(input logic [3:0] op, input logic [31:0] v);
    if32.mdu_op = op; if32.d1 = v; if32.start = 1'b1;
    @(posedge clk); #1;
    if32.start = 1'b0;
    chk("mt_busy", {63'h0, if32.busy}, 64'h0);
  endtask

  initial begin
    int n;
    if32.start = 0; if32.mdu_op = 0; if32.req = 0; if32.d1 = 0; if32.d2 = 0;
    if16.start = 0; if16.mdu_op = 0; if16.req = 0; if16.d1 = 0; if16.d2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'h0, if32.busy}, 64'h0);
    chk("rst_done", {63'h0, if32.done}, 64'h0);
    chk("rst_hilo", {if32.hi, if32.lo}, 64'h0);
    reset = 1'b1;

    run32(4'd1, 32'hFFFFFFFE, 32'd3, {32'hFFFFFFFF, 32'hFFFFFFFA}, 5, 0);
    run32(4'd4, 32'd100, 32'd7, {32'd2, 32'd14}, 10, 0);
    run32(4'd3, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 10, 0);
    run32(4'd3, 32'h1234, 32'd0, {32'h1234, 32'hFFFFFFFF}, 10, 0);
    run32(4'd3, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 10, 0);

    mt32(4'd5, 32'd5);
    mt32(4'd6, 32'd6);
    chk("mthi_mtlo", {if32.hi, if32.lo}, {32'd5, 32'd6});
    run32(4'd8, 32'h10, 32'h10, {32'd5, 32'h106}, 5, 0);
    run32(4'd10, 32'h10, 32'h10, {32'd5, 32'd6}, 5, 0);

    // req blocks the accept
    if32.mdu_op = 4'd1; if32.d1 = 32'd3; if32.d2 = 32'd4;
    if32.start = 1'b1; if32.req = 1'b1;
    @(posedge clk); #1;
    if32.start = 1'b0; if32.req = 1'b0;
    chk("req_block_busy", {63'h0, if32.busy}, 64'h0);
    chk("req_block_hilo", {if32.hi, if32.lo}, {32'd5, 32'd6});

    run32(4'd1, 32'd3, 32'd4, {32'd0, 32'd12}, 5, 2);          // req mid-flight
    run32(4'd2, 32'd7, 32'd9, {32'd0, 32'd63}, 5, 1);          // mtlo on last busy cycle
    run32(4'd7, 32'hFFFFFFFF, 32'd2, {32'd0, 32'd61}, 5, 0);   // 63 + (-2)
    run32(4'd9, 32'hFFFFFFFF, 32'd2, {32'd0, 32'd63}, 5, 0);   // 61 - (-2)

    // nope and reserved opcodes are ignored
    for (int k = 0; k < 2; k++) begin
      if32.mdu_op = (k == 0) ? 4'd0 : 4'd12; if32.start = 1'b1;
      @(posedge clk); #1;
      if32.start = 1'b0;
      chk("nop_busy", {63'h0, if32.busy}, 64'h0);
    end

    // reset in busy cycle 3 of a div
    if32.mdu_op = 4'd4; if32.d1 = 32'd100; if32.d2 = 32'd7; if32.start = 1'b1;
    @(posedge clk); #1;
    if32.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("pre_rst_busy", {63'h0, if32.busy}, 64'h1);
    #1 reset = 1'b0;
    #1;
    chk("abort_busy", {63'h0, if32.busy}, 64'h0);
    chk("abort_hilo", {if32.hi, if32.lo}, 64'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    run32(4'd1, 32'd7, 32'd6, {32'd0, 32'd42}, 5, 0);

    // narrow build: single busy cycle
    q16.push_back({16'hFFFE, 16'h0001});
    if16.mdu_op = 4'd2; if16.d1 = 16'hFFFF; if16.d2 = 16'hFFFF; if16.start = 1'b1;
    @(posedge clk); #1;
    if16.start = 1'b0;
    n = 0;
    while (if16.busy === 1'b1 && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    chk("busy16_cycles", 64'(n), 64'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("q32_drained", 64'(q32.size()), 64'd0);
    chk("q16_drained", 64'(q16.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
